// File: rtl/dual_rail_level_monitor.sv
// rtl/dual_rail_level_monitor.sv - synchronise, debounce and fault-check a complementary rail pair
// Optional glitch counter output enabled by `define DUAL_RAIL_GLITCH_CNT_EN.
module dual_rail_level_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             c_in,
    input  logic             d_in,
    output logic             level_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] rise_cnt,
    output logic [CNT_W-1:0] fall_cnt,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
`ifdef DUAL_RAIL_GLITCH_CNT_EN
    ,
    output logic [CNT_W-1:0] glitch_cnt
`endif
);

    localparam logic [7:0]       LAST_CNT = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0]       FULL_CNT = 8'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_LOW   = 2'd0,
        S_HIGH  = 2'd1,
        S_FAULT = 2'd2
    } state_e;

    logic             c_meta_q, c_s_q, d_meta_q, d_s_q;
    state_e           state_q, state_d;
    logic [7:0]       stab_q, stab_d;
    logic [7:0]       inv_q, inv_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d, fall_q, fall_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
    logic [CNT_W-1:0] fall_cnt_q, fall_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             pair_valid;
    logic             fault_entry;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v,
                                              input logic inc, input logic clear);
        if (clear)
            return '0;
        else if (inc && (v != CNT_MAX))
            return v + CNT_W'(1);
        else
            return v;
    endfunction

    assign pair_valid = c_s_q ^ d_s_q;

    always_comb begin
        state_d     = state_q;
        stab_d      = stab_q;
        inv_d       = inv_q;
        level_d     = level_q;
        rise_d      = 1'b0;
        fall_d      = 1'b0;
        fault_entry = 1'b0;
        if (en) begin
            if (pair_valid)
                inv_d = '0;
            else if (inv_q != FULL_CNT)
                inv_d = inv_q + 8'd1;
            case (state_q)
                S_LOW, S_HIGH: begin
                    // Fault entry is checked first; it needs an invalid pair, debounce a valid one.
                    if (!pair_valid && (inv_q == LAST_CNT)) begin
                        state_d     = S_FAULT;
                        stab_d      = '0;
                        fault_entry = 1'b1;
                    end else if (pair_valid && (c_s_q != level_q)) begin
                        if (stab_q == LAST_CNT) begin
                            state_d = c_s_q ? S_HIGH : S_LOW;
                            level_d = c_s_q;
                            stab_d  = '0;
                        end else begin
                            stab_d = stab_q + 8'd1;
                        end
                    end else begin
                        stab_d = '0;
                    end
                end
                S_FAULT: begin
                    if (pair_valid) begin
                        if (stab_q == LAST_CNT) begin
                            state_d = c_s_q ? S_HIGH : S_LOW;
                            level_d = c_s_q;
                            stab_d  = '0;
                        end else begin
                            stab_d = stab_q + 8'd1;
                        end
                    end else begin
                        stab_d = '0;
                    end
                end
                default: state_d = S_LOW;
            endcase
            rise_d = level_d & ~level_q;
            fall_d = ~level_d & level_q;
        end
        rise_cnt_d = bump(rise_cnt_q, rise_d, clr);
        fall_cnt_d = bump(fall_cnt_q, fall_d, clr);
        err_cnt_d  = bump(err_cnt_q, fault_entry, clr);
        err_d      = clr ? 1'b0 : (err_q | fault_entry);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_meta_q   <= 1'b0;
            c_s_q      <= 1'b0;
            d_meta_q   <= 1'b1;
            d_s_q      <= 1'b1;
            state_q    <= S_LOW;
            stab_q     <= '0;
            inv_q      <= '0;
            level_q    <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            err_q      <= 1'b0;
            rise_cnt_q <= '0;
            fall_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            c_meta_q   <= c_in;
            c_s_q      <= c_meta_q;
            d_meta_q   <= d_in;
            d_s_q      <= d_meta_q;
            state_q    <= state_d;
            stab_q     <= stab_d;
            inv_q      <= inv_d;
            level_q    <= level_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            err_q      <= err_d;
            rise_cnt_q <= rise_cnt_d;
            fall_cnt_q <= fall_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

`ifdef DUAL_RAIL_GLITCH_CNT_EN
    logic             glitch_hit;
    logic [CNT_W-1:0] glitch_cnt_q, glitch_cnt_d;

    // A debounce run abandoned before acceptance: counter drops from nonzero, state unchanged.
    assign glitch_hit   = en && (state_q != S_FAULT) && (state_d == state_q)
                          && (stab_q != '0) && (stab_d == '0);
    assign glitch_cnt_d = bump(glitch_cnt_q, glitch_hit, clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            glitch_cnt_q <= '0;
        else
            glitch_cnt_q <= glitch_cnt_d;
    end

    assign glitch_cnt = glitch_cnt_q;
`endif

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign rise_cnt   = rise_cnt_q;
    assign fall_cnt   = fall_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign err        = err_q | (state_q == S_FAULT);

endmodule

// File: tb/tb_dual_rail_level_monitor.sv
// tb/tb_dual_rail_level_monitor.sv - self-checking bench for dual_rail_level_monitor
module tb_dual_rail_level_monitor;

    localparam int ST   = 4;
    localparam int CW   = 8;
    localparam int CMAX = 255;

    logic          clk, rst_n, en, clr, c_in, d_in;
    logic          level_out, rise_pulse, fall_pulse, err;
    logic [CW-1:0] rise_cnt, fall_cnt, err_cnt;
`ifdef DUAL_RAIL_GLITCH_CNT_EN
    logic [CW-1:0] glitch_cnt;
`endif

    int n_total, n_bad;

    bit m_c0, m_c1, m_d0, m_d1;
    bit m_level, m_fault, m_errf, m_rp, m_fp;
    int m_run, m_bad_run, m_rise, m_fall, m_errc, m_glitch;

    typedef struct {
        bit c, d, e, cl;
        int n;
        bit lvl, er;
        int rc, fc, ec, gc;
    } vec_t;
    vec_t tbl[13];

    dual_rail_level_monitor #(.STABLE_CYCLES(ST), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr       (clr),
        .c_in      (c_in),
        .d_in      (d_in),
        .level_out (level_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .rise_cnt  (rise_cnt),
        .fall_cnt  (fall_cnt),
        .err       (err),
        .err_cnt   (err_cnt)
`ifdef DUAL_RAIL_GLITCH_CNT_EN
        ,
        .glitch_cnt(glitch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1);
    end

    function automatic int sat(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_c0 = 0; m_c1 = 0; m_d0 = 1; m_d1 = 1;
        m_level = 0; m_fault = 0; m_errf = 0; m_rp = 0; m_fp = 0;
        m_run = 0; m_bad_run = 0; m_rise = 0; m_fall = 0; m_errc = 0; m_glitch = 0;
    endtask

    // Reference: rails seen two clocks late; a level is accepted after ST qualifying cycles in a row.
    task automatic model_step(input bit e, input bit cl, input bit c, input bit d);
        bit cs, ds, ok, prev;
        cs = m_c1; ds = m_d1; ok = (cs != ds);
        m_c1 = m_c0; m_c0 = c; m_d1 = m_d0; m_d0 = d;
        m_rp = 0; m_fp = 0;
        if (e) begin
            prev = m_level;
            if (!m_fault) begin
                if (!ok && (m_bad_run + 1 >= ST)) begin
                    m_fault = 1; m_errf = 1; m_errc = sat(m_errc); m_run = 0;
                end else if (ok && (cs != m_level)) begin
                    m_run++;
                    if (m_run == ST) begin m_level = cs; m_run = 0; end
                end else begin
                    if (m_run != 0) m_glitch = sat(m_glitch);
                    m_run = 0;
                end
            end else begin
                if (ok) begin
                    m_run++;
                    if (m_run == ST) begin m_fault = 0; m_level = cs; m_run = 0; end
                end else begin
                    m_run = 0;
                end
            end
            m_bad_run = ok ? 0 : m_bad_run + 1;
            if (m_level && !prev) begin m_rp = 1; m_rise = sat(m_rise); end
            if (!m_level && prev) begin m_fp = 1; m_fall = sat(m_fall); end
        end
        if (cl) begin
            m_rise = 0; m_fall = 0; m_errc = 0; m_glitch = 0; m_errf = 0;
        end
    endtask

    task automatic check_model();
        logic [27:0] got, want;
        got  = {level_out, rise_pulse, fall_pulse, err, rise_cnt, fall_cnt, err_cnt};
        want = {m_level, m_rp, m_fp, m_errf | m_fault, CW'(m_rise), CW'(m_fall), CW'(m_errc)};
        check("model_outputs", {4'b0, got}, {4'b0, want});
`ifdef DUAL_RAIL_GLITCH_CNT_EN
        check("model_glitch_cnt", {24'b0, glitch_cnt}, m_glitch);
`endif
    endtask

    task automatic tick(input bit c, input bit d, input bit e, input bit cl);
        c_in = c; d_in = d; en = e; clr = cl;
        @(posedge clk);
        model_step(e, cl, c, d);
        #1;
        check_model();
    endtask

    initial begin
        n_total = 0; n_bad = 0;
        rst_n = 0; en = 1; clr = 0; c_in = 1; d_in = 0;
        model_reset();

        tbl[0]  = '{c:0, d:1, e:1, cl:0, n:8,  lvl:0, er:0, rc:1, fc:1, ec:0, gc:0};
        tbl[1]  = '{c:1, d:0, e:1, cl:0, n:3,  lvl:0, er:0, rc:1, fc:1, ec:0, gc:0};
        tbl[2]  = '{c:0, d:1, e:1, cl:0, n:6,  lvl:0, er:0, rc:1, fc:1, ec:0, gc:1};
        tbl[3]  = '{c:1, d:0, e:1, cl:0, n:8,  lvl:1, er:0, rc:2, fc:1, ec:0, gc:1};
        tbl[4]  = '{c:1, d:1, e:1, cl:0, n:10, lvl:1, er:1, rc:2, fc:1, ec:1, gc:1};
        tbl[5]  = '{c:0, d:1, e:1, cl:0, n:8,  lvl:0, er:1, rc:2, fc:2, ec:1, gc:1};
        tbl[6]  = '{c:0, d:1, e:1, cl:1, n:1,  lvl:0, er:0, rc:0, fc:0, ec:0, gc:0};
        tbl[7]  = '{c:1, d:0, e:1, cl:0, n:8,  lvl:1, er:0, rc:1, fc:0, ec:0, gc:0};
        tbl[8]  = '{c:0, d:0, e:1, cl:0, n:10, lvl:1, er:1, rc:1, fc:0, ec:1, gc:0};
        tbl[9]  = '{c:1, d:0, e:1, cl:0, n:8,  lvl:1, er:1, rc:1, fc:0, ec:1, gc:0};
        tbl[10] = '{c:1, d:0, e:1, cl:1, n:1,  lvl:1, er:0, rc:0, fc:0, ec:0, gc:0};
        tbl[11] = '{c:0, d:1, e:0, cl:0, n:10, lvl:1, er:0, rc:0, fc:0, ec:0, gc:0};
        tbl[12] = '{c:0, d:1, e:1, cl:0, n:8,  lvl:0, er:0, rc:0, fc:1, ec:0, gc:0};

        // Reset with the rails already showing a high level, then the first rise.
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {4'b0, level_out, rise_pulse, fall_pulse, err, rise_cnt, fall_cnt, err_cnt}, 0);
        @(negedge clk);
        rst_n = 1;
        for (int k = 1; k <= 8; k++) begin
            tick(1, 0, 1, 0);
            check("rise_level", level_out, (k >= 6));
            check("rise_pulse", rise_pulse, (k == 6));
        end
        check("rise_cnt_after_first", rise_cnt, 1);

        for (int i = 0; i < 13; i++) begin
            for (int t = 0; t < tbl[i].n; t++)
                tick(tbl[i].c, tbl[i].d, tbl[i].e, tbl[i].cl);
            check($sformatf("vec%0d_level", i), level_out, tbl[i].lvl);
            check($sformatf("vec%0d_err", i), err, tbl[i].er);
            check($sformatf("vec%0d_rise_cnt", i), rise_cnt, tbl[i].rc);
            check($sformatf("vec%0d_fall_cnt", i), fall_cnt, tbl[i].fc);
            check($sformatf("vec%0d_err_cnt", i), err_cnt, tbl[i].ec);
`ifdef DUAL_RAIL_GLITCH_CNT_EN
            check($sformatf("vec%0d_glitch_cnt", i), glitch_cnt, tbl[i].gc);
`endif
        end

        // Fault timing: entry six clocks after the rails collide, level held, exit falls.
        repeat (8) tick(1, 0, 1, 0);
        for (int k = 1; k <= 10; k++) begin
            tick(1, 1, 1, 0);
            check("fault_err", err, (k >= 6));
            check("fault_err_cnt", err_cnt, (k >= 6));
            check("fault_level_held", level_out, 1);
        end
        for (int k = 1; k <= 8; k++) begin
            tick(0, 1, 1, 0);
            check("fault_exit_fall", fall_pulse, (k == 6));
            check("fault_exit_level", level_out, (k < 6));
            check("fault_err_sticky", err, 1);
        end
        tick(0, 1, 1, 1);
        check("fault_clr_err", err, 0);

        // en freeze mid-debounce: two counts held, rails toggled, two more finish it.
        repeat (4) tick(1, 0, 1, 0);
        for (int k = 1; k <= 6; k++) begin
            if (k <= 3) tick(0, 1, 0, 0);
            else        tick(1, 0, 0, 0);
            check("freeze_no_rise", rise_pulse, 0);
            check("freeze_no_fall", fall_pulse, 0);
            check("freeze_level", level_out, 0);
        end
        for (int k = 1; k <= 4; k++) begin
            tick(1, 0, 1, 0);
            check("resume_rise", rise_pulse, (k == 2));
            check("resume_level", level_out, (k >= 2));
        end

        // Saturation of both edge counters.
        for (int p = 0; p < 300; p++) begin
            repeat (8) tick(0, 1, 1, 0);
            repeat (8) tick(1, 0, 1, 0);
        end
        check("sat_rise_cnt", rise_cnt, CMAX);
        check("sat_fall_cnt", fall_cnt, CMAX);

        // clr on the edge that produces a rise wins over the increment.
        for (int r = 0; r < 2; r++) begin
            repeat (8) tick(0, 1, 1, 0);
            repeat (5) tick(1, 0, 1, 0);
            tick(1, 0, 1, 1);
            check("clr_with_rise_pulse", rise_pulse, 1);
            check("clr_with_rise_cnt", rise_cnt, 0);
            tick(1, 0, 1, 0);
            check("clr_after_rise_cnt", rise_cnt, 0);
        end

        // Randomised rails, enable and clear against the model.
        for (int s = 0; s < 150; s++) begin
            int kind, len;
            bit rc, rd;
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, 10);
            rc   = 1'($urandom_range(0, 1));
            rd   = (kind < 8) ? ~rc : rc;
            for (int t = 0; t < len; t++)
                tick(rc, rd, ($urandom_range(0, 11) != 0), ($urandom_range(0, 40) == 0));
        end

        // Asynchronous reset while in FAULT with a nonzero fault count.
        repeat (8) tick(0, 1, 1, 0);
        repeat (8) tick(1, 1, 1, 0);
        check("pre_rst_err", err, 1);
        check("pre_rst_err_cnt_nonzero", (err_cnt != 0), 1);
        rst_n = 0;
        #2;
        check("async_rst_outputs", {4'b0, level_out, rise_pulse, fall_pulse, err, rise_cnt, fall_cnt, err_cnt}, 0);
`ifdef DUAL_RAIL_GLITCH_CNT_EN
        check("async_rst_glitch", glitch_cnt, 0);
`endif
        @(negedge clk);
        rst_n = 1;
        model_reset();
        repeat (8) tick(0, 1, 1, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
